// File: rtl/layer_mixer_pkg.sv
// Shared definitions for the pixel compositor and the VGA timing generator.
// Holds the colour width, the default transparency key, the sync polarity
// and a small helper that decides whether a sprite pixel is visible.
package layer_mixer_pkg;

    localparam int RGB_W = 12;

    // Magenta is reserved as the "see-through" colour in the sprite ROMs.
    localparam logic [RGB_W-1:0] KEY_RGB_DEFAULT = 12'hF0F;

    // Colour driven outside the active area.
    localparam logic [RGB_W-1:0] RGB_BLANK = 12'h000;

    // VGA syncs are active-low; the idle level is the inverse.
    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

    // A layer covers the pixel when its box flag is set and its ROM colour
    // is not the transparency key.
    function automatic logic is_opaque(
        input logic             in_box,
        input logic [RGB_W-1:0] colour,
        input logic [RGB_W-1:0] key
    );
        return in_box && (colour != key);
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Parameterised shift register with enable.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset, loads RESET_VAL into every stage
//   srst   - synchronous reset, loads RESET_VAL into every stage
//   en     - shift enable
//   d      - input word
//   q      - word delayed by DEPTH enabled cycles (d itself when DEPTH is 0)
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift chain: stage 0 takes d, each later stage takes its predecessor.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RESET_VAL;
                    end
                end else if (srst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RESET_VAL;
                    end
                end else if (en) begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i];
                    end
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/layer_mixer.sv
// Pixel compositor between the sprite layers and the VGA pins.
// Box flags and syncs are delayed to line up with the ROM colours, the
// frontmost opaque layer (lowest index) is chosen, and colour plus syncs are
// registered together. A player/hazard overlap flag is accumulated per frame
// and published at each vsync falling edge.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   pix_en               - pixel tick; all state advances only when high
//   video_on             - active-area flag, aligned with col/row
//   hsync_in, vsync_in   - active-low syncs, aligned with col/row
//   hit                  - per-layer in-box flags, aligned with col/row
//   layer_rgb            - layer colours (layer i at [12i+11:12i]), ROM_LAT ticks late
//   bg_rgb               - background colour, same alignment as layer_rgb
//   rgb, hsync, vsync    - registered pixel colour and syncs to the DAC
//   collide              - previous frame had a player/hazard overlap
//   frame_tick           - one-clk pulse at each vsync falling edge
module layer_mixer
    import layer_mixer_pkg::*;
#(
    parameter int                    NUM_LAYERS  = 4,
    parameter int                    ROM_LAT     = 1,
    parameter logic [RGB_W-1:0]      KEY_RGB     = KEY_RGB_DEFAULT,
    parameter int                    PLAYER_IDX  = 1,
    parameter logic [NUM_LAYERS-1:0] HAZARD_MASK = 4'b0100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pix_en,
    input  logic                        video_on,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic [NUM_LAYERS-1:0]       hit,
    input  logic [RGB_W*NUM_LAYERS-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    output logic [RGB_W-1:0]            rgb,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        collide,
    output logic                        frame_tick
);

    localparam int CTL_W = NUM_LAYERS + 3;

    // Delay-line fill value: no hits, blanked, syncs idle.
    localparam logic [CTL_W-1:0] CTL_RST = {{NUM_LAYERS{1'b0}}, 1'b0, SYNC_IDLE, SYNC_IDLE};

    // The player can never be its own hazard.
    localparam logic [NUM_LAYERS-1:0] PLAYER_BIT = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << PLAYER_IDX;
    localparam logic [NUM_LAYERS-1:0] HAZARD_EFF = HAZARD_MASK & ~PLAYER_BIT;

    logic [CTL_W-1:0]      ctl_d_s;
    logic [NUM_LAYERS-1:0] hit_d_s;
    logic                  video_on_d_s;
    logic                  hsync_d_s;
    logic                  vsync_d_s;
    logic [NUM_LAYERS-1:0] opaque_s;
    logic [RGB_W-1:0]      pick_s;
    logic                  found_s;
    logic [RGB_W-1:0]      mux_rgb_s;
    logic                  overlap_s;
    logic                  vs_fall_s;

    logic [RGB_W-1:0]      rgb_r;
    logic                  hsync_r;
    logic                  vsync_r;
    logic                  collide_r;
    logic                  frame_tick_r;
    logic                  acc_r;

    pipe_delay #(
        .WIDTH     (CTL_W),
        .DEPTH     (ROM_LAT),
        .RESET_VAL (CTL_RST)
    ) u_ctl_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (1'b0),
        .en    (pix_en),
        .d     ({hit, video_on, hsync_in, vsync_in}),
        .q     (ctl_d_s)
    );

    assign {hit_d_s, video_on_d_s, hsync_d_s, vsync_d_s} = ctl_d_s;

    // Per-layer visibility once flags and colours are aligned.
    always_comb begin
        opaque_s = {NUM_LAYERS{1'b0}};
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque_s[i] = is_opaque(hit_d_s[i], layer_rgb[i*RGB_W +: RGB_W], KEY_RGB);
        end
    end

    // Priority mux: the first opaque layer from the front wins, else background.
    always_comb begin
        pick_s  = bg_rgb;
        found_s = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (opaque_s[i] && !found_s) begin
                pick_s  = layer_rgb[i*RGB_W +: RGB_W];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        if (video_on_d_s) begin
            mux_rgb_s = pick_s;
        end else begin
            mux_rgb_s = RGB_BLANK;
        end
    end

    // Overlap detect and frame boundary. vsync_r always holds the previous
    // delayed vsync, so comparing it with the current one finds the falling edge.
    always_comb begin
        overlap_s = video_on_d_s && opaque_s[PLAYER_IDX] && (|(opaque_s & HAZARD_EFF));
        vs_fall_s = pix_en && (vsync_r == SYNC_IDLE) && (vsync_d_s == SYNC_ACTIVE);
    end

    // Output stage: colour and syncs registered together to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r   <= RGB_BLANK;
            hsync_r <= SYNC_IDLE;
            vsync_r <= SYNC_IDLE;
        end else if (pix_en) begin
            rgb_r   <= mux_rgb_s;
            hsync_r <= hsync_d_s;
            vsync_r <= vsync_d_s;
        end else begin
            rgb_r   <= rgb_r;
            hsync_r <= hsync_r;
            vsync_r <= vsync_r;
        end
    end

    // Collision accumulator: an overlap on the boundary tick belongs to the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r        <= 1'b0;
            collide_r    <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= vs_fall_s;
            if (vs_fall_s) begin
                collide_r <= acc_r;
                acc_r     <= overlap_s;
            end else if (pix_en) begin
                collide_r <= collide_r;
                acc_r     <= acc_r | overlap_s;
            end else begin
                collide_r <= collide_r;
                acc_r     <= acc_r;
            end
        end
    end

    assign rgb        = rgb_r;
    assign hsync      = hsync_r;
    assign vsync      = vsync_r;
    assign collide    = collide_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_layer_mixer.sv
// Self-checking bench for layer_mixer: table-driven priority vectors,
// directed multi-cycle sequences, and randomized traffic against a
// reference model built from the compositing rules.
module tb_layer_mixer;

    localparam int NL     = 4;
    localparam int LAT    = 1;
    localparam int PLAYER = 1;
    localparam logic [3:0] HAZ = 4'b0100;
    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [3:0]  hit;
    logic [47:0] layer_rgb;
    logic [11:0] bg_rgb;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        collide;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    layer_mixer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hit        (hit),
        .layer_rgb  (layer_rgb),
        .bg_rgb     (bg_rgb),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .collide    (collide),
        .frame_tick (frame_tick)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] h;
        logic       v;
        logic       hs;
        logic       vs;
    } ctl_t;

    ctl_t        hist[$];
    ctl_t        m_cur;
    ctl_t        m_d;
    logic [11:0] e_rgb;
    logic        e_hs, e_vs, e_col, e_ft;
    logic        m_acc, m_dvs, m_ov;
    logic [3:0]  m_op;
    int          m_win;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < LAT; i++) hist.push_back('{4'b0000, 1'b0, 1'b1, 1'b1});
        e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_col = 1'b0; e_ft = 1'b0;
        m_acc = 1'b0; m_dvs = 1'b1;
    endtask

    // One clock edge of the model, evaluated with the inputs present at that edge.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            e_ft = 1'b0;
            if (pix_en) begin
                m_cur = '{hit, video_on, hsync_in, vsync_in};
                hist.push_front(m_cur);
                m_d = hist.pop_back();
                for (int i = 0; i < NL; i++)
                    m_op[i] = m_d.h[i] && (layer_rgb[i*12 +: 12] != KEY);
                m_win = -1;
                for (int i = 0; i < NL; i++)
                    if (m_win < 0 && m_op[i]) m_win = i;
                if (!m_d.v)        e_rgb = 12'h000;
                else if (m_win < 0) e_rgb = bg_rgb;
                else               e_rgb = layer_rgb[m_win*12 +: 12];
                m_ov = m_d.v && m_op[PLAYER] && ((m_op & HAZ & ~(4'b0001 << PLAYER)) != 4'b0000);
                if (m_dvs && !m_d.vs) begin
                    e_col = m_acc;
                    m_acc = m_ov;
                    e_ft  = 1'b1;
                end else begin
                    m_acc = m_acc | m_ov;
                end
                m_dvs = m_d.vs;
                e_hs  = m_d.hs;
                e_vs  = m_d.vs;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rgb"}, rgb, e_rgb);
        chk({tag, ".hsync"}, {11'b0, hsync}, {11'b0, e_hs});
        chk({tag, ".vsync"}, {11'b0, vsync}, {11'b0, e_vs});
        chk({tag, ".collide"}, {11'b0, collide}, {11'b0, e_col});
        chk({tag, ".frame_tick"}, {11'b0, frame_tick}, {11'b0, e_ft});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic px(input logic [3:0] h, input logic v, input logic vs);
        hit = h; video_on = v; vsync_in = vs; hsync_in = 1'b1; pix_en = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [3:0]  h;
        logic [11:0] l0, l1, l2, l3, bg;
        logic        v;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   low_ticks;
    int   first_low;
    int   ft_seen;
    int   vcnt;

    initial begin
        vecs[0] = '{4'b0011, 12'hF0F, 12'h0A0, 12'h111, 12'h222, 12'h00F, 1'b1, 12'h0A0};
        vecs[1] = '{4'b0011, 12'h123, 12'h0A0, 12'h111, 12'h222, 12'h00F, 1'b1, 12'h123};
        vecs[2] = '{4'b0000, 12'h123, 12'h0A0, 12'h111, 12'h222, 12'h00F, 1'b1, 12'h00F};
        vecs[3] = '{4'b0011, 12'h123, 12'h0A0, 12'h111, 12'h222, 12'h00F, 1'b0, 12'h000};
        vecs[4] = '{4'b1100, 12'h123, 12'h0A0, 12'hF0F, 12'h456, 12'h00F, 1'b1, 12'h456};
        vecs[5] = '{4'b1111, 12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F, 12'h0C0, 1'b1, 12'h0C0};
        vecs[6] = '{4'b0100, 12'h123, 12'h0A0, 12'hABC, 12'h456, 12'h00F, 1'b1, 12'hABC};
        vecs[7] = '{4'b1010, 12'h777, 12'hF0F, 12'h111, 12'h999, 12'h00F, 1'b1, 12'h999};

        rst_n = 1'b1; pix_en = 1'b0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        hit = 4'b0000; layer_rgb = 48'h0; bg_rgb = 12'h000;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;

        // Priority table
        foreach (vecs[i]) begin
            hit = vecs[i].h; video_on = vecs[i].v; bg_rgb = vecs[i].bg;
            layer_rgb = {vecs[i].l3, vecs[i].l2, vecs[i].l1, vecs[i].l0};
            hsync_in = 1'b1; vsync_in = 1'b1; pix_en = 1'b1;
            repeat (3) tick();
            chk($sformatf("table%0d", i), rgb, vecs[i].exp);
        end

        // Mid-stream reset, then exact latency of the first pixel
        hit = 4'b0011; video_on = 1'b1; layer_rgb = {12'h222, 12'h111, 12'h0A0, 12'h123};
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rst.rgb", rgb, 12'h000);
        chk("rst.hsync", {11'b0, hsync}, 12'h001);
        chk("rst.vsync", {11'b0, vsync}, 12'h001);
        chk("rst.collide", {11'b0, collide}, 12'h000);
        chk("rst.frame_tick", {11'b0, frame_tick}, 12'h000);
        hit = 4'b0000; video_on = 1'b0;
        tick();
        rst_n = 1'b1;
        px(4'b0010, 1'b1, 1'b1);
        chk("lat.edge1", rgb, 12'h000);
        px(4'b0000, 1'b0, 1'b1);
        chk("lat.edge2", rgb, 12'h0A0);
        px(4'b0000, 1'b0, 1'b1);
        chk("lat.edge3", rgb, 12'h000);

        // Slow pixel clock with a 3-pixel hsync pulse
        low_ticks = 0; first_low = -1; ft_seen = 0;
        for (int c = 0; c < 80; c++) begin
            pix_en = (c % 4 == 0);
            if (pix_en) hsync_in = !((c / 4) >= 5 && (c / 4) <= 7);
            tick();
            if (frame_tick) ft_seen++;
            if (pix_en && !hsync) begin
                low_ticks++;
                if (first_low < 0) first_low = c / 4;
            end
        end
        chk("hs.low_ticks", 12'(low_ticks), 12'd3);
        chk("hs.first_low", 12'(first_low), 12'(5 + LAT));
        chk("hs.no_frame_tick", 12'(ft_seen), 12'd0);

        // Collision sequences: layer1 player, layer2 hazard
        layer_rgb = {12'hF0F, 12'hA00, 12'h0A0, 12'hF0F};
        bg_rgb = 12'h00F;
        px(4'b0000, 1'b1, 1'b1); px(4'b0000, 1'b0, 1'b0); px(4'b0000, 1'b0, 1'b0);
        px(4'b0000, 1'b0, 1'b1); px(4'b0000, 1'b1, 1'b1);
        px(4'b0110, 1'b1, 1'b1); px(4'b0000, 1'b1, 1'b1); px(4'b0000, 1'b1, 1'b1);
        chk("col.midframe", {11'b0, collide}, 12'h000);
        px(4'b0000, 1'b0, 1'b0);
        chk("ft.before_edge", {11'b0, frame_tick}, 12'h000);
        px(4'b0000, 1'b0, 1'b0);
        chk("ft.edge", {11'b0, frame_tick}, 12'h001);
        chk("col.edge", {11'b0, collide}, 12'h001);
        px(4'b0000, 1'b0, 1'b0);
        chk("ft.one_clk", {11'b0, frame_tick}, 12'h000);
        chk("col.stable", {11'b0, collide}, 12'h001);
        px(4'b0000, 1'b1, 1'b1); px(4'b0000, 1'b1, 1'b1); px(4'b0000, 1'b1, 1'b1);
        px(4'b0000, 1'b0, 1'b0); px(4'b0000, 1'b0, 1'b0);
        chk("col.clean_frame", {11'b0, collide}, 12'h000);

        // Overlap where the hazard pixel is the key colour
        px(4'b0000, 1'b0, 1'b1);
        layer_rgb = {12'hF0F, 12'hF0F, 12'h0A0, 12'hF0F};
        px(4'b0110, 1'b1, 1'b1); px(4'b0000, 1'b1, 1'b1);
        layer_rgb = {12'hF0F, 12'hA00, 12'h0A0, 12'hF0F};
        px(4'b0000, 1'b0, 1'b0); px(4'b0000, 1'b0, 1'b0);
        chk("col.keyed", {11'b0, collide}, 12'h000);

        // Overlap outside the active area
        px(4'b0000, 1'b0, 1'b1);
        px(4'b0110, 1'b0, 1'b1); px(4'b0000, 1'b1, 1'b1);
        px(4'b0000, 1'b0, 1'b0); px(4'b0000, 1'b0, 1'b0);
        chk("col.blanked", {11'b0, collide}, 12'h000);

        // Overlap on the very tick of the vsync falling edge
        px(4'b0000, 1'b0, 1'b1); px(4'b0000, 1'b1, 1'b1); px(4'b0000, 1'b1, 1'b1);
        px(4'b0110, 1'b1, 1'b0); px(4'b0000, 1'b0, 1'b0);
        chk("edge_ov.ft", {11'b0, frame_tick}, 12'h001);
        chk("edge_ov.col_old", {11'b0, collide}, 12'h000);
        px(4'b0000, 1'b0, 1'b1); px(4'b0000, 1'b1, 1'b1);
        px(4'b0000, 1'b0, 1'b0); px(4'b0000, 1'b0, 1'b0);
        chk("edge_ov.col_new", {11'b0, collide}, 12'h001);

        // Randomized traffic against the model, with one mid-stream reset
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rand_rst0");
        tick();
        rst_n = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 1200; c++) begin
            if (c == 600) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rand_rst1");
                tick();
                rst_n = 1'b1;
            end
            pix_en   = ($urandom % 3) != 0;
            hit      = 4'($urandom);
            video_on = ($urandom % 5) != 0;
            hsync_in = ($urandom % 6) != 0;
            vsync_in = (vcnt % 40) >= 3;
            if (pix_en) vcnt++;
            for (int i = 0; i < NL; i++)
                layer_rgb[i*12 +: 12] = (($urandom % 4) == 0) ? KEY : 12'($urandom);
            bg_rgb = 12'($urandom);
            tick();
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_mixer.md
# layer_mixer

Pixel compositor between the sprite layers (cloud, player, spikes, etc.) and the VGA output pins. Each sprite layer supplies a combinational in-box flag plus a ROM colour that arrives a fixed number of pixel ticks later. The block realigns flags, syncs and colours, then resolves priority and the transparency colour key. It drives registered RGB and syncs, and latches a per-frame player/hazard collision flag for the game FSM.

## Interface
- NUM_LAYERS, 4, number of sprite layers; index 0 is frontmost.
- ROM_LAT, 1, pixel ticks from flag to valid layer colour (block-ROM read latency).
- KEY_RGB, 12'hF0F, colour treated as transparent.
- PLAYER_IDX, 1, layer index of the player sprite.
- HAZARD_MASK, 4'b0100, layers that kill the player on overlap.
- Reset is asynchronous and active-low; one clock.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel tick; all state advances only when high.
- video_on  in  1  active-area flag, aligned with col/row.
- hsync_in  in  1  active-low hsync, aligned with col/row.
- vsync_in  in  1  active-low vsync, aligned with col/row.
- hit  in  NUM_LAYERS  per-layer in-box flags, aligned with col/row.
- layer_rgb  in  12*NUM_LAYERS  layer colours; layer i at bits [12i+11:12i]; valid ROM_LAT ticks after hit.
- bg_rgb  in  12  background colour, same alignment as layer_rgb.
- rgb  out  12  pixel colour to DAC, {R,G,B} 4 bits each.
- hsync  out  1  delayed hsync.
- vsync  out  1  delayed vsync.
- collide  out  1  previous frame had a player/hazard overlap.
- frame_tick  out  1  one-clk pulse at each vsync falling edge.

## Operation
- Stage A: shift register, ROM_LAT deep, for hit, video_on, hsync_in, vsync_in; shifts on pix_en.
- Opaque test: layer i is opaque when delayed hit[i]=1 and layer_rgb slice is not KEY_RGB.
- Priority: lowest-index opaque layer wins. If no layer is opaque, bg_rgb is used. If delayed video_on=0, the result is 12'h000 regardless of hits.
- Stage B: register the selected colour, delayed hsync and delayed vsync into rgb/hsync/vsync on pix_en.
- Collision accumulator acc:
  - Sets when delayed video_on is high, PLAYER_IDX is opaque, and any HAZARD_MASK layer is opaque.
  - The PLAYER_IDX bit in HAZARD_MASK is ignored.
- Frame boundary: on a pix_en where delayed vsync goes 1→0:
  - collide <= acc, acc cleared.
  - frame_tick=1 for that clk only.
  - If that same tick also has an overlap, the overlap counts toward the new frame: acc ends at 1, and collide takes the old acc.
- Reset: rgb=0, hsync=1, vsync=1, collide=0, frame_tick=0, acc=0, delay lines filled with hit=0, video_on=0, syncs=1.
- Reset asserted mid-frame: everything returns to the values above immediately. The first frame_tick after release comes at the first real vsync falling edge.

## Timing
- Latency from col/row (and the hit/video_on/sync inputs aligned with them) to rgb/hsync/vsync: ROM_LAT+1 pix_en ticks. Syncs and colour stay mutually aligned.
- pix_en low: all registers hold; frame_tick stays 0.
- frame_tick and collide update on the same clk edge.
- collide is stable for a whole frame.
- No combinational path from any input to any output.

## Structure
- Shared package/header holds:
  - RGB_W=12.
  - KEY_RGB default.
  - Sync polarity constant (active-low). Also used by the VGA timing generator.
- One sub-module: pipe_delay (parameterised width/depth shift register with enable and async active-low reset to a parameter value). It is instantiated once for {hit, video_on, hsync, vsync}.
- Priority select is a for-loop priority mux inside layer_mixer.

## Test plan
- Reset with rst_n=0 mid-stream → rgb=000, hsync=vsync=1, collide=0. After release, the first valid pixel appears exactly ROM_LAT+1 pix_en ticks after its inputs.
- hit=4'b0011, layer0 rgb=F0F, layer1 rgb=0A0, bg=00F → rgb=0A0. With layer0 rgb=123 → rgb=123. With hit=0 → 00F. With video_on=0 → 000.
- pix_en toggling 1-in-4 with a 3-pixel hsync pulse → hsync low for exactly 3 pix_en ticks, aligned to the rgb latency.
- Player (layer1) and hazard (layer2) opaque on one pixel mid-frame → collide=0 until the next vsync falling edge. Then collide=1 and frame_tick=1 for one clk. A clean following frame → collide=0.
- Overlap only where hazard rgb=F0F → no collision. Overlap with video_on=0 → no collision.
- Overlap on the exact tick of the vsync falling edge, after a clean frame → collide=0 at that edge and collide=1 at the next edge.
